// File: rtl/regfile.sv
// -----------------------------------------------------------------------------
// regfile -- 32-entry x DATA_WIDTH general-purpose register file
//
// One write port and two independent combinational read ports. Register 0 is
// hardwired to zero: writes to it are dropped and reads of it return zero.
// Three 5-to-32 one-hot decoders are used: one for the write port (gated by
// ctrl_writeEnable) and one per read port. Each read decoder enables exactly
// one register onto its bus through an AND-OR mux, so the buses never float.
// There is no read-during-write bypass. A read of the register being written
// returns the old value before the clock edge and the new value after it.
//
// Ports
//   clock             in   1           rising-edge clock for all register writes
//   ctrl_reset        in   1           asynchronous active-high clear of r1..r31
//   ctrl_writeEnable  in   1           write data_writeReg into ctrl_writeReg
//   ctrl_writeReg     in   5           write register index
//   ctrl_readRegA     in   5           read port A register index
//   ctrl_readRegB     in   5           read port B register index
//   data_writeReg     in   DATA_WIDTH  write data
//   data_readRegA     out  DATA_WIDTH  contents of register ctrl_readRegA
//   data_readRegB     out  DATA_WIDTH  contents of register ctrl_readRegB
// -----------------------------------------------------------------------------
module regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [4:0]            ctrl_writeReg,
  input  logic [4:0]            ctrl_readRegA,
  input  logic [4:0]            ctrl_readRegB,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB
);

  // 5-to-32 one-hot decoder shared by the write port and both read ports.
  function automatic logic [NUM_REGS-1:0] decode_5to32(input logic [4:0] idx);
    logic [NUM_REGS-1:0] onehot;
    onehot      = {NUM_REGS{1'b0}};
    onehot[idx] = 1'b1;
    return onehot;
  endfunction

  // Storage exists only for r1..r31; r0 is a constant zero row.
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

  logic [NUM_REGS-1:0]   wr_sel_s;
  logic [NUM_REGS-1:0]   wr_en_s;
  logic [NUM_REGS-1:0]   rd_sel_a_s;
  logic [NUM_REGS-1:0]   rd_sel_b_s;
  logic [DATA_WIDTH-1:0] rd_bus_a_s;
  logic [DATA_WIDTH-1:0] rd_bus_b_s;

  // Decode the write and read indices into one-hot enables.
  always_comb begin
    wr_sel_s   = decode_5to32(ctrl_writeReg);
    wr_en_s    = wr_sel_s & {NUM_REGS{ctrl_writeEnable}};
    rd_sel_a_s = decode_5to32(ctrl_readRegA);
    rd_sel_b_s = decode_5to32(ctrl_readRegB);
  end

  // Next-state per register: load when enabled, otherwise hold.
  always_comb begin
    for (int i = 1; i < NUM_REGS; i++) begin
      if (wr_en_s[i]) begin
        regs_d[i] = data_writeReg;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage; the asynchronous reset overrides any write in flight.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // AND-OR read muxes: each selected row is ORed onto its bus.
  // Row 0 never contributes, so index 0 reads back as zero.
  always_comb begin
    rd_bus_a_s = {DATA_WIDTH{1'b0}};
    rd_bus_b_s = {DATA_WIDTH{1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      rd_bus_a_s = rd_bus_a_s | (regs_q[i] & {DATA_WIDTH{rd_sel_a_s[i]}});
      rd_bus_b_s = rd_bus_b_s | (regs_q[i] & {DATA_WIDTH{rd_sel_b_s[i]}});
    end
  end

  // Drive the read ports. The row-0 select forces zero explicitly.
  always_comb begin
    if (rd_sel_a_s[0]) begin
      data_readRegA = {DATA_WIDTH{1'b0}};
    end else begin
      data_readRegA = rd_bus_a_s;
    end
    if (rd_sel_b_s[0]) begin
      data_readRegB = {DATA_WIDTH{1'b0}};
    end else begin
      data_readRegB = rd_bus_b_s;
    end
  end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        clock;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic [31:0] data_writeReg;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;

  int vectors;
  int miscompares;

  // Reference model: contents of r0..r31, with r0 never written.
  logic [31:0] model [32];

  regfile #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .data_writeReg    (data_writeReg),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    return model[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Single write through one rising edge; the model is updated at the edge.
  task automatic do_write(input logic [4:0] idx, input logic [31:0] data, input logic we);
    @(negedge clock);
    ctrl_writeEnable = we;
    ctrl_writeReg    = idx;
    data_writeReg    = data;
    @(posedge clock);
    if (we && !ctrl_reset && idx != 5'd0) model[idx] = data;
    #1;
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_reset();
    // Fill with random contents first.
    for (int i = 0; i < 20; i++) do_write(5'($urandom_range(0, 31)), $urandom, 1'b1);
    @(negedge clock);
    #2;
    ctrl_reset = 1'b1;
    model_clear();
    #1;
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      #1;
      vectors++;
      if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_during idx=%0d got A=%h B=%h want 0", i, data_readRegA, data_readRegB);
      end
    end
    @(negedge clock);
    ctrl_reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(i);
      #1;
      vectors++;
      if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_after idx=%0d got A=%h B=%h want 0", i, data_readRegA, data_readRegB);
      end
    end
  endtask

  task automatic test_write_read();
    do_write(5'd5, 32'hDEADBEEF, 1'b1);
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd5;
    #1;
    vectors++;
    if (data_readRegA !== 32'hDEADBEEF || data_readRegB !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_r5 got A=%h B=%h want deadbeef", data_readRegA, data_readRegB);
    end
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(i);
      #1;
      vectors++;
      if (data_readRegA !== model_read(5'(i)) || data_readRegB !== model_read(5'(i))) begin
        miscompares++;
        $display("FAIL write_r5_others idx=%0d got A=%h B=%h want %h", i, data_readRegA, data_readRegB, model_read(5'(i)));
      end
    end
  endtask

  task automatic test_r0();
    do_write(5'd0, 32'hFFFFFFFF, 1'b1);
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd0;
    #1;
    vectors++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_hardwired got A=%h B=%h want 0", data_readRegA, data_readRegB);
    end
  endtask

  task automatic test_write_disable();
    for (int i = 0; i < 3; i++) do_write(5'd7, 32'h12345678, 1'b0);
    ctrl_readRegA = 5'd7;
    ctrl_readRegB = 5'd7;
    #1;
    vectors++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      miscompares++;
      $display("FAIL write_disable got A=%h B=%h want 0", data_readRegA, data_readRegB);
    end
  endtask

  task automatic test_read_during_write();
    do_write(5'd9, 32'h1, 1'b1);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd9;
    data_writeReg    = 32'hA5A5A5A5;
    ctrl_readRegA    = 5'd9;
    ctrl_readRegB    = 5'd10;
    #1;
    vectors++;
    if (data_readRegA !== 32'h1 || data_readRegB !== model_read(5'd10)) begin
      miscompares++;
      $display("FAIL rdw_before got A=%h B=%h want A=00000001 B=%h", data_readRegA, data_readRegB, model_read(5'd10));
    end
    @(posedge clock);
    model[9] = 32'hA5A5A5A5;
    #1;
    ctrl_writeEnable = 1'b0;
    vectors++;
    if (data_readRegA !== 32'hA5A5A5A5 || data_readRegB !== model_read(5'd10)) begin
      miscompares++;
      $display("FAIL rdw_after got A=%h B=%h want A=a5a5a5a5 B=%h", data_readRegA, data_readRegB, model_read(5'd10));
    end
  endtask

  task automatic test_reset_midwrite();
    do_write(5'd31, 32'hCAFEF00D, 1'b1);
    @(negedge clock);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd31;
    data_writeReg    = 32'h13572468;
    ctrl_readRegA    = 5'd31;
    ctrl_readRegB    = 5'd31;
    #2;
    ctrl_reset = 1'b1;
    model_clear();
    #1;
    vectors++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_immediate got A=%h B=%h want 0", data_readRegA, data_readRegB);
    end
    @(posedge clock);
    #1;
    vectors++;
    if (data_readRegA !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_edge got A=%h want 0", data_readRegA);
    end
    @(negedge clock);
    #2;
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b0;
    #1;
    vectors++;
    if (data_readRegA !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_release got A=%h want 0", data_readRegA);
    end
    do_write(5'd31, 32'h0BADF00D, 1'b1);
    #1;
    vectors++;
    if (data_readRegA !== 32'h0BADF00D || data_readRegB !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL reset_mid_rewrite got A=%h B=%h want 0badf00d", data_readRegA, data_readRegB);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [4:0]  widx;
    logic [31:0] wdata;
    for (int n = 0; n < 400; n++) begin
      we    = 1'($urandom_range(0, 1));
      widx  = 5'($urandom_range(0, 31));
      wdata = $urandom;
      @(negedge clock);
      ctrl_writeEnable = we;
      ctrl_writeReg    = widx;
      data_writeReg    = wdata;
      // Bias reads toward the write target to exercise read-during-write.
      ctrl_readRegA    = ($urandom_range(0, 3) == 0) ? widx : 5'($urandom_range(0, 31));
      ctrl_readRegB    = 5'($urandom_range(0, 31));
      #1;
      vectors++;
      if (data_readRegA !== model_read(ctrl_readRegA) || data_readRegB !== model_read(ctrl_readRegB)) begin
        miscompares++;
        $display("FAIL random_pre n=%0d A[%0d]=%h B[%0d]=%h want %h %h", n, ctrl_readRegA, data_readRegA,
                 ctrl_readRegB, data_readRegB, model_read(ctrl_readRegA), model_read(ctrl_readRegB));
      end
      @(posedge clock);
      if (we && widx != 5'd0) model[widx] = wdata;
      #1;
      vectors++;
      if (data_readRegA !== model_read(ctrl_readRegA) || data_readRegB !== model_read(ctrl_readRegB)) begin
        miscompares++;
        $display("FAIL random_post n=%0d A[%0d]=%h B[%0d]=%h want %h %h", n, ctrl_readRegA, data_readRegA,
                 ctrl_readRegB, data_readRegB, model_read(ctrl_readRegA), model_read(ctrl_readRegB));
      end
    end
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101, 1'b1);
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(31 - i);
      exp_a = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
      exp_b = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101;
      #1;
      vectors++;
      if (data_readRegA !== exp_a || data_readRegB !== exp_b) begin
        miscompares++;
        $display("FAIL sweep A=%0d B=%0d got %h %h want %h %h", i, 31 - i, data_readRegA, data_readRegB, exp_a, exp_b);
      end
    end
  endtask

  initial begin
    vectors          = 0;
    miscompares      = 0;
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    data_writeReg    = 32'h0;
    model_clear();
    repeat (2) @(negedge clock);
    ctrl_reset = 1'b0;

    test_reset();
    test_write_read();
    test_r0();
    test_write_disable();
    test_read_during_write();
    test_reset_midwrite();
    test_random();
    test_reset();
    test_sweep();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
